// File: rtl/mio_bridge.sv
// rtl/mio_bridge.sv - memory/IO bridge: block RAM, LED/switch GPIO, seven-segment word and cycle counter
// Define MIO_COUNTER_EN to map the free-running counter at 0xF000_0004; otherwise that address is unmapped.

module mio_bridge #(
    parameter int RAM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        CPU_MIO,
    input  logic [31:0] addr,
    input  logic [31:0] data_out,
    output logic [31:0] data_in,
    output logic        MIO_ready,
    output logic [9:0]  ram_addr,
    output logic [31:0] ram_din,
    output logic        ram_we,
    input  logic [31:0] ram_dout,
    input  logic [15:0] sw,
    input  logic [3:0]  btn,
    output logic [15:0] led,
    output logic [31:0] seg_data,
    output logic        bus_err
);

    localparam int WCW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;
    typedef enum logic [2:0] {R_RAM, R_SEG, R_GPIO, R_CNT, R_NONE} region_t;

    function automatic region_t decode(input logic [29:0] wa);
        region_t r;
        r = R_NONE;
        if (wa[29:10] == 20'd0)         r = R_RAM;
        else if (wa == 30'h3800_0000)   r = R_SEG;
        else if (wa == 30'h3C00_0000)   r = R_GPIO;
`ifdef MIO_COUNTER_EN
        else if (wa == 30'h3C00_0001)   r = R_CNT;
`endif
        return r;
    endfunction

    state_t         state_q, state_d;
    region_t        region_q, region_d;
    logic           wr_q, wr_d;
    logic [WCW-1:0] wait_q, wait_d;
    logic [31:0]    data_in_q, data_in_d;
    logic           ready_q, ready_d;
    logic [9:0]     ram_addr_q, ram_addr_d;
    logic [31:0]    ram_din_q, ram_din_d;
    logic           ram_we_q, ram_we_d;
    logic [15:0]    led_q, led_d;
    logic [31:0]    seg_q, seg_d;
    logic           err_q, err_d;
`ifdef MIO_COUNTER_EN
    logic [31:0]    cnt_q, cnt_d;
`endif

    region_t req_region;
    logic    unused_addr_bits;

    assign req_region       = decode(addr[31:2]);
    assign unused_addr_bits = ^addr[1:0];

    always_comb begin
        state_d    = state_q;
        region_d   = region_q;
        wr_d       = wr_q;
        wait_d     = wait_q;
        data_in_d  = data_in_q;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        ram_we_d   = 1'b0;
        led_d      = led_q;
        seg_d      = seg_q;
        err_d      = err_q;
`ifdef MIO_COUNTER_EN
        cnt_d      = cnt_q + 32'd1;
`endif
        case (state_q)
            S_IDLE: begin
                if (CPU_MIO && (MemRead || MemWrite)) begin
                    region_d   = req_region;
                    wr_d       = MemWrite;
                    ram_addr_d = addr[11:2];
                    ram_din_d  = data_out;
                    ram_we_d   = MemWrite && (req_region == R_RAM);
                    wait_d     = '0;
                    state_d    = S_ACCESS;
                end
            end
            S_ACCESS: begin
                state_d = S_DONE;
                // ram_din_q doubles as the latched store data for every target
                case (region_q)
                    R_RAM:  if (!wr_q) state_d = S_WAIT;
                    R_SEG:  if (wr_q) seg_d = ram_din_q; else data_in_d = seg_q;
                    R_GPIO: if (wr_q) led_d = ram_din_q[15:0]; else data_in_d = {12'd0, btn, sw};
`ifdef MIO_COUNTER_EN
                    R_CNT:  if (wr_q) cnt_d = ram_din_q; else data_in_d = cnt_q;
`endif
                    default: begin
                        err_d = 1'b1;
                        if (!wr_q) data_in_d = 32'd0;
                    end
                endcase
            end
            S_WAIT: begin
                if (wait_q == WCW'(RAM_LAT - 1)) begin
                    data_in_d = ram_dout;
                    state_d   = S_DONE;
                end else begin
                    wait_d = wait_q + WCW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            region_q   <= R_NONE;
            wr_q       <= 1'b0;
            wait_q     <= '0;
            data_in_q  <= 32'd0;
            ready_q    <= 1'b0;
            ram_addr_q <= 10'd0;
            ram_din_q  <= 32'd0;
            ram_we_q   <= 1'b0;
            led_q      <= 16'd0;
            seg_q      <= 32'd0;
            err_q      <= 1'b0;
`ifdef MIO_COUNTER_EN
            cnt_q      <= 32'd0;
`endif
        end else begin
            state_q    <= state_d;
            region_q   <= region_d;
            wr_q       <= wr_d;
            wait_q     <= wait_d;
            data_in_q  <= data_in_d;
            ready_q    <= ready_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            ram_we_q   <= ram_we_d;
            led_q      <= led_d;
            seg_q      <= seg_d;
            err_q      <= err_d;
`ifdef MIO_COUNTER_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    // Masking with reset keeps a write from landing when reset arrives during ACCESS.
    assign ram_we    = ram_we_q & ~reset;
    assign data_in   = data_in_q;
    assign MIO_ready = ready_q;
    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;
    assign led       = led_q;
    assign seg_data  = seg_q;
    assign bus_err   = err_q;

endmodule

// File: tb/tb_mio_bridge.sv
// tb/tb_mio_bridge.sv - directed and randomized check of mio_bridge against a behavioural model
module tb_mio_bridge;
    localparam int LAT = 1;
    localparam int K_RAM = 0, K_SEG = 1, K_GPIO = 2, K_CNT = 3, K_BAD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite, CPU_MIO;
    logic [31:0] addr, data_out, data_in;
    logic        MIO_ready;
    logic [9:0]  ram_addr;
    logic [31:0] ram_din, ram_dout;
    logic        ram_we;
    logic [15:0] sw, led;
    logic [3:0]  btn;
    logic [31:0] seg_data;
    logic        bus_err;

    mio_bridge #(.RAM_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .CPU_MIO(CPU_MIO),
        .addr(addr), .data_out(data_out), .data_in(data_in), .MIO_ready(MIO_ready),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
        .sw(sw), .btn(btn), .led(led), .seg_data(seg_data), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem  [0:1023];
    logic [31:0] pipe [0:LAT-1];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        pipe[0] <= mem[ram_addr];
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign ram_dout = pipe[LAT-1];

    int          checks = 0;
    int          errors = 0;
    logic [31:0] ref_mem [0:1023];
    logic [31:0] ref_seg, exp_din, cnt_base;
    logic [15:0] ref_led;
    logic        ref_err;
    int          cnt_c;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ref_led = 16'd0; ref_seg = 32'd0; ref_err = 1'b0; exp_din = 32'd0;
        cnt_base = 32'd0; cnt_c = cyc;
    endtask

    task automatic do_reset();
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; CPU_MIO = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic do_access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                             output logic [31:0] rdat, output int lat, output int wec,
                             output logic [9:0] ra, output logic [31:0] rdin, output int ct);
        MemRead = rd; MemWrite = wr; CPU_MIO = 1'b1; addr = a; data_out = d;
        @(posedge clk);
        #1;
        ct = cyc; ra = ram_addr; rdin = ram_din; wec = 0; lat = -1; rdat = 32'd0;
        for (int k = 1; k <= 12; k++) begin
            if (ram_we) wec++;
            if (MIO_ready) begin
                lat = k; rdat = data_in;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        MemRead = 1'b0; MemWrite = 1'b0; CPU_MIO = 1'b0;
        chk("ready_one_cycle", {31'd0, MIO_ready}, 32'd0);
    endtask

    task automatic run_op(input int kind_in, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d, output logic [31:0] got);
        int kind, lat, wec, ct, exp_lat, exp_we;
        logic [9:0]  ra;
        logic [31:0] rdin;
        kind = kind_in;
`ifndef MIO_COUNTER_EN
        if (kind == K_CNT) kind = K_BAD;
`endif
        do_access(rd, wr, a, d, got, lat, wec, ra, rdin, ct);
        exp_lat = 2; exp_we = 0;
        case (kind)
            K_RAM: begin
                chk("ram_addr", {22'd0, ra}, {22'd0, a[11:2]});
                if (wr) begin
                    ref_mem[a[11:2]] = d; exp_we = 1;
                    chk("ram_din", rdin, d);
                end else begin
                    exp_din = ref_mem[a[11:2]]; exp_lat = 2 + LAT;
                end
            end
            K_SEG:  if (wr) ref_seg = d; else exp_din = ref_seg;
            K_GPIO: if (wr) ref_led = d[15:0]; else exp_din = {12'd0, btn, sw};
            K_CNT: begin
                if (wr) begin cnt_base = d; cnt_c = ct + 1; end
                else exp_din = cnt_base + 32'(ct - cnt_c);
            end
            default: begin
                ref_err = 1'b1;
                if (!wr) exp_din = 32'd0;
            end
        endcase
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("we_pulses", 32'(wec), 32'(exp_we));
        chk("data_in", got, exp_din);
        chk("led", {16'd0, led}, {16'd0, ref_led});
        chk("seg_data", seg_data, ref_seg);
        chk("bus_err", {31'd0, bus_err}, {31'd0, ref_err});
    endtask

    initial begin
        logic [31:0] got, a, d;
        int cnt_ready, cnt_we, kind, r;
        logic rd, wr;
        for (int i = 0; i < 1024; i++) begin mem[i] = 32'd0; ref_mem[i] = 32'd0; end
        for (int i = 0; i < LAT; i++) pipe[i] = 32'd0;
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; CPU_MIO = 1'b0;
        addr = 32'd0; data_out = 32'd0; sw = 16'd0; btn = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, MIO_ready}, 32'd0);
        chk("rst_data_in", data_in, 32'd0);
        chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
        chk("rst_ram_addr", {22'd0, ram_addr}, 32'd0);
        chk("rst_ram_din", ram_din, 32'd0);
        chk("rst_led", {16'd0, led}, 32'd0);
        chk("rst_seg", seg_data, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
        reset = 1'b0;
        model_reset();

        run_op(K_CNT, 1'b1, 1'b0, 32'hF000_0004, 32'd0, got);
        run_op(K_RAM, 1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, got);
        run_op(K_RAM, 1'b1, 1'b0, 32'h0000_0010, 32'd0, got);
        chk("ram_readback", got, 32'h1234_5678);

        sw = 16'h00A5; btn = 4'h3;
        run_op(K_GPIO, 1'b1, 1'b0, 32'hF000_0000, 32'd0, got);
        chk("gpio_read", got, 32'h0003_00A5);
        run_op(K_GPIO, 1'b0, 1'b1, 32'hF000_0000, 32'hFFFF_8001, got);
        chk("led_value", {16'd0, led}, 32'h0000_8001);

        run_op(K_CNT, 1'b0, 1'b1, 32'hF000_0004, 32'hFFFF_FFFE, got);
        repeat (3) @(posedge clk);
        #1;
        run_op(K_CNT, 1'b1, 1'b0, 32'hF000_0004, 32'd0, got);
`ifdef MIO_COUNTER_EN
        chk("cnt_wrap", got, 32'h0000_0003);
`else
        chk("cnt_absent", got, 32'd0);
        chk("cnt_absent_err", {31'd0, bus_err}, 32'd1);
`endif

        run_op(K_BAD, 1'b1, 1'b0, 32'h4000_0000, 32'd0, got);
        chk("unmapped_read", got, 32'd0);
        run_op(K_SEG, 1'b1, 1'b1, 32'hE000_0000, 32'h0000_00FF, got);
        chk("both_strobes_seg", seg_data, 32'h0000_00FF);
        chk("err_sticky", {31'd0, bus_err}, 32'd1);
        run_op(K_RAM, 1'b0, 1'b1, 32'h0000_001C, 32'hA5A5_0007, got);

        MemRead = 1'b1; CPU_MIO = 1'b1; addr = 32'h0000_0010;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1; MemRead = 1'b0; CPU_MIO = 1'b0;
        @(posedge clk); #1;
        chk("rst_wait_ready", {31'd0, MIO_ready}, 32'd0);
        reset = 1'b0;
        model_reset();
        @(posedge clk); #1;
        chk("rst_wait_ready2", {31'd0, MIO_ready}, 32'd0);
        chk("rst_wait_err", {31'd0, bus_err}, 32'd0);
        run_op(K_RAM, 1'b1, 1'b0, 32'h0000_0010, 32'd0, got);
        chk("after_rst_read", got, 32'h1234_5678);

        MemWrite = 1'b1; CPU_MIO = 1'b1; addr = 32'h0000_001C; data_out = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        chk("access_we_high", {31'd0, ram_we}, 32'd1);
        reset = 1'b1; MemWrite = 1'b0; CPU_MIO = 1'b0;
        #1;
        chk("access_we_masked", {31'd0, ram_we}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        run_op(K_RAM, 1'b1, 1'b0, 32'h0000_001C, 32'd0, got);
        chk("write_not_committed", got, 32'hA5A5_0007);

        MemWrite = 1'b1; CPU_MIO = 1'b0; addr = 32'hF000_0000; data_out = 32'h0000_FFFF;
        cnt_ready = 0; cnt_we = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (MIO_ready) cnt_ready++;
            if (ram_we) cnt_we++;
        end
        MemWrite = 1'b0;
        chk("nomio_ready", 32'(cnt_ready), 32'd0);
        chk("nomio_we", 32'(cnt_we), 32'd0);
        chk("nomio_led", {16'd0, led}, {16'd0, ref_led});

        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 4);
            r = $urandom_range(0, 7);
            rd = (r == 0) || (r < 4);
            wr = (r == 0) || (r >= 4);
            d = $urandom;
            sw = 16'($urandom); btn = 4'($urandom);
            case (kind)
                K_RAM:  a = {20'd0, 10'($urandom_range(0, 15)), 2'($urandom)};
                K_SEG:  a = {30'h3800_0000, 2'($urandom)};
                K_GPIO: a = {30'h3C00_0000, 2'($urandom)};
                K_CNT:  a = {30'h3C00_0001, 2'($urandom)};
                default: a = {4'(4 + $urandom_range(0, 9)), 28'($urandom)};
            endcase
            run_op(kind, rd, wr, a, d, got);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
